// File: rtl/duty_ramp.sv
// duty_ramp: slew-rate limiter feeding the PWM duty input.
// Accepts targets over valid/ready, walks o_duty toward the target by at most
// STEP counts per 1024-clock PWM period, and holds one pending target while a
// ramp is running.
// Optional feature: define DUTY_RAMP_ABORT_EN to add i_abort (emergency
// force-to-zero that overrides everything except reset).
module duty_ramp #(
    parameter int STEP = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
`ifdef DUTY_RAMP_ABORT_EN
    input  logic       i_abort,
`endif
    input  logic [9:0] i_tgt_duty,
    input  logic       i_tgt_vld,
    output logic       o_tgt_rdy,
    output logic [9:0] o_duty,
    output logic       o_busy,
    output logic       o_at_tgt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    // STEP widened so that STEP=512 survives the add/subtract unchanged
    localparam logic [10:0] STEP_W = 11'(STEP);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [9:0]         r_tick_cnt;
    logic [9:0]         r_duty;
    logic [9:0]         r_tgt;
    logic [9:0]         r_pend;
    logic               r_pend_vld;
    logic               r_busy;
    logic               r_at_tgt;

    logic [9:0]         w_duty_nxt;
    logic [9:0]         w_tgt_nxt;
    logic [9:0]         w_pend_nxt;
    logic               w_pend_vld_nxt;
    logic               w_tick;
    logic               w_accept;
    logic               w_abort;
    logic               w_at;
    logic signed [10:0] w_diff;
    logic [10:0]        w_mag;
    logic [9:0]         w_duty_step;

`ifdef DUTY_RAMP_ABORT_EN
    assign w_abort = i_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Period boundary: the edge where the counter wraps 0x3FF -> 0x000
    assign w_tick    = (r_tick_cnt == 10'h3FF);
    // The pending slot is the only back-pressure; abort also blocks intake
    assign o_tgt_rdy = !r_pend_vld && !w_abort;
    assign w_accept  = i_tgt_vld && o_tgt_rdy;
    assign w_at      = (r_duty == r_tgt);

    assign o_duty    = r_duty;
    assign o_busy    = r_busy;
    assign o_at_tgt  = r_at_tgt;

    // Next duty on a tick: land on target when within STEP, else move by STEP.
    // No overflow is possible because a full step never passes the target.
    always_comb begin
        w_diff = $signed({1'b0, r_tgt}) - $signed({1'b0, r_duty});
        w_mag  = w_diff[10] ? $unsigned(-w_diff) : $unsigned(w_diff);
        if (w_mag <= STEP_W) begin
            w_duty_step = r_tgt;
        end else if (!w_diff[10]) begin
            w_duty_step = 10'({1'b0, r_duty} + STEP_W);
        end else begin
            w_duty_step = 10'({1'b0, r_duty} - STEP_W);
        end
    end

    // Next-state and datapath updates for the IDLE/RAMP controller
    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_tgt_nxt      = r_tgt;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        if (w_abort) begin
            w_state_nxt    = S_IDLE;
            w_duty_nxt     = '0;
            w_tgt_nxt      = '0;
            w_pend_vld_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_tgt_nxt = i_tgt_duty;
                        if (i_tgt_duty != r_duty) begin
                            w_state_nxt = S_RAMP;
                        end
                    end
                end
                S_RAMP: begin
                    // Anything accepted mid-ramp, including on the landing
                    // cycle, parks in the pending slot.
                    if (w_accept) begin
                        w_pend_nxt     = i_tgt_duty;
                        w_pend_vld_nxt = 1'b1;
                    end
                    if (w_at) begin
                        if (r_pend_vld) begin
                            w_tgt_nxt      = r_pend;
                            w_pend_vld_nxt = 1'b0;
                        end else if (!w_accept) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (w_tick) begin
                        w_duty_nxt = w_duty_step;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers; the period counter never stops except on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tick_cnt <= '0;
            r_duty     <= '0;
            r_tgt      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_at_tgt   <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 10'd1;
            r_duty     <= w_duty_nxt;
            r_tgt      <= w_tgt_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_busy     <= (w_state_nxt == S_RAMP);
            r_at_tgt   <= w_at;
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Bench for duty_ramp: directed scenarios against spec-derived constants plus
// randomized traffic checked cycle by cycle against a behavioural model.
module tb_duty_ramp;

    localparam int STEP   = 8;
    localparam int STEP_B = 510;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, vld = 1'b0, abort = 1'b0;
    logic [9:0] tgt = '0;
    logic       rdy, busy, at;
    logic [9:0] duty;

    logic       rst_b = 1'b1, vld_b = 1'b0, abort_b = 1'b0;
    logic [9:0] tgt_b = '0;
    logic       rdy_b, busy_b, at_b;
    logic [9:0] duty_b;

    int checks = 0;
    int failures = 0;

    duty_ramp #(.STEP(STEP)) u_dut (
        .i_clk(clk), .i_rst(rst),
`ifdef DUTY_RAMP_ABORT_EN
        .i_abort(abort),
`endif
        .i_tgt_duty(tgt), .i_tgt_vld(vld), .o_tgt_rdy(rdy),
        .o_duty(duty), .o_busy(busy), .o_at_tgt(at)
    );

    duty_ramp #(.STEP(STEP_B)) u_dut_b (
        .i_clk(clk), .i_rst(rst_b),
`ifdef DUTY_RAMP_ABORT_EN
        .i_abort(abort_b),
`endif
        .i_tgt_duty(tgt_b), .i_tgt_vld(vld_b), .o_tgt_rdy(rdy_b),
        .o_duty(duty_b), .o_busy(busy_b), .o_at_tgt(at_b)
    );

    // Behavioural model of u_dut: integers and a queue for the pending slot
    int m_duty = 0, m_tgt = 0, m_ph = 0, m_od, m_ot;
    bit m_ramp = 0, m_busy = 0, m_at = 1, m_acc, m_tk;
    int m_pend[$];

    always @(posedge clk) begin
        if (rst) begin
            m_duty = 0; m_tgt = 0; m_ph = 0; m_ramp = 0; m_busy = 0; m_at = 1;
            m_pend.delete();
        end else begin
            m_acc = vld && (m_pend.size() == 0) && !abort;
            m_od  = m_duty;
            m_ot  = m_tgt;
            m_tk  = (m_ph == 1023);
            m_ph  = (m_ph + 1) % 1024;
            if (abort) begin
                m_duty = 0; m_tgt = 0; m_ramp = 0;
                m_pend.delete();
            end else if (m_ramp) begin
                if (m_duty == m_tgt) begin
                    if (m_pend.size() != 0) m_tgt = m_pend.pop_front();
                    else if (m_acc) m_pend.push_back(int'(tgt));
                    else m_ramp = 0;
                end else begin
                    if (m_tk) begin
                        if (m_tgt > m_duty) m_duty = (m_duty + STEP < m_tgt) ? m_duty + STEP : m_tgt;
                        else m_duty = (m_duty - STEP > m_tgt) ? m_duty - STEP : m_tgt;
                    end
                    if (m_acc) m_pend.push_back(int'(tgt));
                end
            end else if (m_acc) begin
                m_tgt  = int'(tgt);
                m_ramp = (m_tgt != m_duty);
            end
            m_at   = (m_od == m_ot);
            m_busy = m_ramp;
        end
    end

    // Advance to the negedge just after the next period boundary of u_dut
    task automatic tick_wait();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_ph != 0 && n < 1100);
    endtask

    // Wait until duty_b changes; ok reports whether it changed in time
    task automatic wait_b_change(output bit ok);
        logic [9:0] prev = duty_b;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (duty_b == prev && n < 1100);
        ok = (duty_b != prev);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (duty !== 10'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", duty); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (at !== 1'b1) begin failures++; $display("FAIL reset_at_tgt got=%b exp=1", at); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    endtask

    task automatic test_ramp_up();
        rst = 1'b0;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            if (i == 5) begin vld = 1'b1; tgt = 10'd100; end
            else vld = 1'b0;
            if (i == 8) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL up_busy got=%b exp=1", busy); end
            end
            if (i == 1023) begin
                checks++; if (duty !== 10'd0) begin failures++; $display("FAIL up_pre_tick got=%0d exp=0", duty); end
            end
            if (i == 1024) begin
                checks++; if (duty !== 10'd8) begin failures++; $display("FAIL up_tick1 got=%0d exp=8", duty); end
            end
        end
        for (int k = 2; k <= 13; k++) begin
            int e = (8 * k > 100) ? 100 : 8 * k;
            tick_wait();
            checks++; if (duty !== 10'(e)) begin failures++; $display("FAIL up_tick%0d got=%0d exp=%0d", k, duty, e); end
            checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL up_rdy got=%b exp=1", rdy); end
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL up_busy_end got=%b exp=0", busy); end
        checks++; if (at !== 1'b1) begin failures++; $display("FAIL up_at_end got=%b exp=1", at); end
    endtask

    task automatic test_ramp_down();
        vld = 1'b1; tgt = 10'd3;
        @(negedge clk);
        vld = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            int e = (100 - 8 * k < 3) ? 3 : 100 - 8 * k;
            tick_wait();
            checks++; if (duty !== 10'(e)) begin failures++; $display("FAIL down_tick%0d got=%0d exp=%0d", k, duty, e); end
        end
        repeat (2) @(negedge clk);
        // target equal to current duty while idle: no ramp at all
        vld = 1'b1; tgt = 10'd3;
        @(negedge clk);
        vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL eq_busy got=%b exp=0", busy); end
        end
        checks++; if (at !== 1'b1) begin failures++; $display("FAIL eq_at got=%b exp=1", at); end
    endtask

    task automatic test_pending();
        int n = 0;
        vld = 1'b1; tgt = 10'd100;
        @(negedge clk);
        vld = 1'b0;
        repeat (3) tick_wait();
        checks++; if (duty !== 10'd27) begin failures++; $display("FAIL pend_pre got=%0d exp=27", duty); end
        vld = 1'b1; tgt = 10'd50;
        @(negedge clk);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL pend_full got=%b exp=0", rdy); end
        tgt = 10'd700;   // held valid until taken
        for (int k = 1; k <= 10; k++) begin
            int e = (27 + 8 * k > 100) ? 100 : 27 + 8 * k;
            tick_wait();
            checks++; if (duty !== 10'(e)) begin failures++; $display("FAIL pend_up%0d got=%0d exp=%0d", k, duty, e); end
            checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL pend_rdy%0d got=%b exp=0", k, rdy); end
        end
        while (rdy !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 1) begin failures++; $display("FAIL pend_xfer_cycles got=%0d exp=1", n); end
        @(negedge clk);
        vld = 1'b0;
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL pend_700_taken got=%b exp=0", rdy); end
        for (int k = 1; k <= 7; k++) begin
            int e = (100 - 8 * k < 50) ? 50 : 100 - 8 * k;
            tick_wait();
            checks++; if (duty !== 10'(e)) begin failures++; $display("FAIL pend_dn%0d got=%0d exp=%0d", k, duty, e); end
        end
        for (int k = 1; k <= 2; k++) begin
            tick_wait();
            checks++; if (duty !== 10'(50 + 8 * k)) begin failures++; $display("FAIL pend_700_%0d got=%0d exp=%0d", k, duty, 50 + 8 * k); end
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pend_busy got=%b exp=1", busy); end
    endtask

    task automatic test_reset_mid_ramp();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = 1'b1; tgt = 10'd100;
        @(negedge clk);
        vld = 1'b0;
        repeat (6) tick_wait();
        checks++; if (duty !== 10'd48) begin failures++; $display("FAIL rmid_pre got=%0d exp=48", duty); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (duty !== 10'd0) begin failures++; $display("FAIL rmid_duty got=%0d exp=0", duty); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rmid_rdy got=%b exp=1", rdy); end
        checks++; if (at !== 1'b1) begin failures++; $display("FAIL rmid_at got=%b exp=1", at); end
        vld = 1'b1; tgt = 10'd20;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            vld = 1'b0;
            if (i == 1023) begin
                checks++; if (duty !== 10'd0) begin failures++; $display("FAIL rmid_phase_pre got=%0d exp=0", duty); end
            end
            if (i == 1024) begin
                checks++; if (duty !== 10'd8) begin failures++; $display("FAIL rmid_phase got=%0d exp=8", duty); end
            end
        end
    endtask

    // Large-step instance: upper and lower rails reached without wrap
    task automatic test_boundaries();
        int bt[6] = '{1020, -1, 1023, 5, -1, 0};
        int be[6] = '{510, 1020, 1023, 513, 5, 0};
        bit ok;
        rst_b = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (bt[j] >= 0) begin
                vld_b = 1'b1; tgt_b = 10'(bt[j]);
                @(negedge clk);
                vld_b = 1'b0;
            end
            wait_b_change(ok);
            checks++; if (!ok || duty_b !== 10'(be[j])) begin failures++; $display("FAIL bound%0d got=%0d exp=%0d timeout=%b", j, duty_b, be[j], !ok); end
        end
        repeat (3) @(negedge clk);
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL bound_busy got=%b exp=0", busy_b); end
        checks++; if (at_b !== 1'b1) begin failures++; $display("FAIL bound_at got=%b exp=1", at_b); end
    endtask

    task automatic test_random();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            int t;
            @(negedge clk);
            checks++; if (duty !== 10'(m_duty)) begin failures++; $display("FAIL rnd_duty c=%0d got=%0d exp=%0d", c, duty, m_duty); end
            checks++; if (rdy !== (m_pend.size() == 0 && !abort)) begin failures++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, rdy, m_pend.size() == 0 && !abort); end
            checks++; if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_busy); end
            checks++; if (at !== m_at) begin failures++; $display("FAIL rnd_at c=%0d got=%b exp=%b", c, at, m_at); end
            rst = ($urandom_range(0, 2999) == 0);
`ifdef DUTY_RAMP_ABORT_EN
            abort = ($urandom_range(0, 399) == 0);
`endif
            vld = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0) t = m_duty + int'($urandom_range(0, 80)) - 40;
            else t = int'($urandom_range(0, 1023));
            if (t < 0) t = 0;
            if (t > 1023) t = 1023;
            tgt = 10'(t);
        end
        rst = 1'b0; abort = 1'b0; vld = 1'b0;
    endtask

    task automatic test_abort();
`ifdef DUTY_RAMP_ABORT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = 1'b1; tgt = 10'd200;
        @(negedge clk);
        tgt = 10'd50;
        @(negedge clk);
        vld = 1'b0;
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL abort_pend got=%b exp=0", rdy); end
        tick_wait();
        checks++; if (duty !== 10'd8) begin failures++; $display("FAIL abort_pre got=%0d exp=8", duty); end
        abort = 1'b1;
        #1;
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL abort_rdy_low got=%b exp=0", rdy); end
        @(negedge clk);
        checks++; if (duty !== 10'd0) begin failures++; $display("FAIL abort_duty got=%0d exp=0", duty); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        abort = 1'b0;
        #1;
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL abort_rdy_back got=%b exp=1", rdy); end
        tick_wait();
        checks++; if (duty !== 10'd0) begin failures++; $display("FAIL abort_hold got=%0d exp=0", duty); end
`endif
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_pending();
        test_reset_mid_ramp();
        test_boundaries();
        test_random();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
